// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed by a valid/ready FIFO; frames are sent back-to-back.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits (sense chosen by PARITY_ODD).
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(BPS_CNT + 1);
  localparam int IW      = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE   = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   PTR_ONE   = {{AW{1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  // Reject parameter sets the bit counters and FIFO pointers cannot represent.
  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || BPS_CNT < 2) begin : g_bad_cfg
    $error("uart_tx_fifo: illegal parameter set");
  end

`ifdef UART_TX_PARITY_EN
  function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
    return (^word) ^ (PARITY_ODD != 0);
  endfunction
  logic par_q, par_d;
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d, busy_q, busy_d, ready_q, ready_d;
  logic                 push_s, pop_s, empty_s, bit_end_s;
  logic [DATA_BITS-1:0] rd_word_s;

  assign push_s    = tx_valid && ready_q;
  assign empty_s   = (wptr_q == rptr_q);
  assign bit_end_s = (baud_q == BAUD_LAST);
  assign rd_word_s = mem_q[rptr_q[AW-1:0]];

  // Next-state logic: frame sequencer, baud counter and FIFO pointer bookkeeping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q == S_IDLE || bit_end_s) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BAUD_ONE;
    end
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = rd_word_s;
`ifdef UART_TX_PARITY_EN
          par_d   = parity_of(rd_word_s);
`endif
          state_d = S_START;
          txd_d   = 1'b0;
        end else begin
          txd_d = 1'b1;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          idx_d   = '0;
          txd_d   = shift_q[0];
        end else begin
          txd_d = 1'b0;
        end
      end
      S_DATA: begin
        if (bit_end_s && idx_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
          txd_d   = par_q;
`else
          state_d = S_STOP;
          idx_d   = '0;
          txd_d   = 1'b1;
`endif
        end else if (bit_end_s) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_ONE;
          txd_d   = shift_q[1];
        end else begin
          txd_d = shift_q[0];
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          idx_d   = '0;
          txd_d   = 1'b1;
        end else begin
          txd_d = par_q;
        end
      end
`endif
      S_STOP: begin
        // A waiting word chains straight into the next start bit.
        if (bit_end_s && idx_q == STOP_LAST && !empty_s) begin
          pop_s   = 1'b1;
          shift_d = rd_word_s;
`ifdef UART_TX_PARITY_EN
          par_d   = parity_of(rd_word_s);
`endif
          state_d = S_START;
          txd_d   = 1'b0;
        end else if (bit_end_s && idx_q == STOP_LAST) begin
          state_d = S_IDLE;
          txd_d   = 1'b1;
        end else if (bit_end_s) begin
          idx_d = idx_q + IDX_ONE;
        end else begin
          txd_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
    wptr_d  = push_s ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d  = pop_s  ? (rptr_q + PTR_ONE) : rptr_q;
    count_d = wptr_d - rptr_d;
    ready_d = !((wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]));
    busy_d  = (state_d != S_IDLE);
  end

  // State registers with synchronous reset; reset discards the FIFO by clearing pointers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // FIFO storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge sys_clk) begin
    if (push_s) begin
      mem_q[wptr_q[AW-1:0]] <= tx_data;
    end
  end

  assign tx_ready     = ready_q;
  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;
  assign fifo_count   = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a frame-level reference model predicts the line every cycle.
module tb_uart_tx_fifo;
  localparam int CF    = 700;
  localparam int BR    = 100;
  localparam int DB    = 7;
  localparam int SB    = 2;
  localparam int DEPTH = 4;
  localparam int PODD  = 1;
  localparam int BPS   = CF / BR;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_LEN = (1 + DB + PB + SB) * BPS;
  localparam int CNTW      = $clog2(DEPTH) + 1;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic            tx_valid = 1'b0;
  logic [DB-1:0]   tx_data = '0;
  logic            tx_ready, uart_txd, uart_tx_busy;
  logic [CNTW-1:0] fifo_count;

  uart_tx_fifo #(.CLK_FREQ(CF), .UART_BPS(BR), .DATA_BITS(DB), .STOP_BITS(SB),
                 .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_txd(uart_txd), .uart_tx_busy(uart_tx_busy),
    .fifo_count(fifo_count));

  always #5 sys_clk = ~sys_clk;

  int unsigned   n_total = 0;
  int unsigned   n_pass  = 0;
  logic [DB-1:0] mq[$];
  logic [DB-1:0] cur = '0;
  bit            active = 1'b0;
  int            t = 0;
  bit            last_acc = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
  endtask

  // Line level of bit k of a frame carrying word w.
  function automatic logic exp_bit(input logic [DB-1:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= DB) return w[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == DB + 1) return (^w) ^ (PODD != 0);
`endif
    return 1'b1;
  endfunction

  task automatic model_edge(input logic v, input logic [DB-1:0] d, input logic r);
    bit acc;
    last_acc = 1'b0;
    if (r) begin
      mq.delete();
      active = 1'b0;
      t = 0;
      return;
    end
    acc = v && (mq.size() < DEPTH);
    if (active) begin
      t++;
      if (t == FRAME_LEN) begin
        if (mq.size() != 0) begin
          cur = mq.pop_front();
          t = 0;
        end else begin
          active = 1'b0;
        end
      end
    end else if (mq.size() != 0) begin
      cur = mq.pop_front();
      active = 1'b1;
      t = 0;
    end
    if (acc) mq.push_back(d);
    last_acc = acc;
  endtask

  task automatic compare_all();
    check_eq("txd",   uart_txd,     active ? exp_bit(cur, t / BPS) : 1'b1);
    check_eq("busy",  uart_tx_busy, active);
    check_eq("count", fifo_count,   mq.size());
    check_eq("ready", tx_ready,     mq.size() < DEPTH);
  endtask

  // Drive at the falling edge, advance the model at the rising edge, compare at the next falling edge.
  task automatic cycle(input logic v, input logic [DB-1:0] d, input logic r);
    tx_valid = v;
    tx_data  = d;
    sys_rst  = r;
    @(posedge sys_clk);
    model_edge(v, d, r);
    @(negedge sys_clk);
    compare_all();
  endtask

  task automatic push_word(input logic [DB-1:0] w);
    int n = 0;
    do begin
      cycle(1'b1, w, 1'b0);
      n++;
    end while (!last_acc && n < 4 * FRAME_LEN);
    check_eq("push_accept", last_acc, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((active || mq.size() != 0) && n < (DEPTH + 2) * FRAME_LEN) begin
      cycle(1'b0, DB'($urandom), 1'b0);
      n++;
    end
    cycle(1'b0, '0, 1'b0);
    check_eq("drained_idle", uart_tx_busy, 1'b0);
  endtask

  initial begin
    int n;
    bit burst;
    repeat (3) cycle(1'b0, '0, 1'b1);

    push_word(7'h55);
    drain();
    push_word(7'h41);
    drain();

    push_word(7'h23);
    push_word(7'h0F);
    drain();

    for (int i = 0; i < 6; i++) push_word(DB'(7'h10 + i));
    drain();

    // Abort in the middle of data bit 3 with two words still queued.
    for (int i = 0; i < 3; i++) push_word(DB'($urandom));
    n = 0;
    while (!(active && t == 4 * BPS + 2) && n < 2 * FRAME_LEN) begin
      cycle(1'b0, '0, 1'b0);
      n++;
    end
    check_eq("abort_point", mq.size(), 2);
    cycle(1'b0, '0, 1'b1);
    check_eq("abort_txd", uart_txd, 1'b1);
    repeat (3 * FRAME_LEN) cycle(1'b0, DB'($urandom), 1'b0);

    burst = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 299) == 0) burst = ~burst;
      cycle(burst ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0),
            DB'($urandom), $urandom_range(0, 2999) == 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
